// File: rtl/ram_bus_pkg.sv
// Shared types and constants for the ram_bus_master request path.
package ram_bus_pkg;

  localparam int BUS_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    RDATA,
    TURN
  } state_t;

  typedef struct packed {
    logic                 write;
    logic [BUS_WIDTH-1:0] addr;
    logic [BUS_WIDTH-1:0] wdata;
  } req_t;

endpackage

// File: rtl/ram_req_fifo.sv
// Synchronous request queue of req_t; an entry becomes visible on head the cycle after its push.
module ram_req_fifo
  import ram_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clock,
  input  logic n_reset,
  input  logic push,
  input  logic pop,
  input  req_t push_data,
  output req_t head,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  req_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == DEPTH_CNT);
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr_reg];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clock) begin
    if (!n_reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
      else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
    end
  end

endmodule

// File: rtl/tri_buf.sv
// Tri-state driver onto a shared bus: drives data while rw is high, otherwise Z.
module tri_buf #(
  parameter int WIDTH = 8
) (
  input  logic             rw,
  input  logic [WIDTH-1:0] data,
  inout  wire  [WIDTH-1:0] bus
);

  assign bus = rw ? data : {WIDTH{1'bz}};

endmodule

// File: rtl/ram_bus_master.sv
// Sequencer turning queued read/write requests into the shared-bus RAM's two-phase protocol.
// Optional one-cycle bus turnaround after reads: define RAM_MASTER_TURNAROUND_EN.
module ram_bus_master #(
  parameter int BUS_WIDTH  = ram_bus_pkg::BUS_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 n_reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [BUS_WIDTH-1:0] req_addr,
  input  logic [BUS_WIDTH-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [BUS_WIDTH-1:0] rsp_rdata,
  output logic                 busy,
  output logic                 enable,
  output logic                 rw,
  inout  wire  [BUS_WIDTH-1:0] bus
);
  import ram_bus_pkg::*;

  state_t               state_reg;
  state_t               state_next;
  req_t                 cur_reg;
  req_t                 next_req;
  req_t                 head;
  req_t                 push_req;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic                 enable_reg;
  logic                 rw_reg;
  logic                 drive_en_reg;
  logic [BUS_WIDTH-1:0] drive_val_reg;
  logic                 rsp_valid_reg;
  logic [BUS_WIDTH-1:0] rsp_rdata_reg;

  assign push_req  = {req_write, req_addr, req_wdata};
  assign req_ready = !full;
  assign busy      = (state_reg != IDLE) || !empty;
  assign enable    = enable_reg;
  assign rw        = rw_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign next_req  = pop ? head : cur_reg;

  ram_req_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .n_reset  (n_reset),
    .push     (req_valid && !full),
    .pop      (pop),
    .push_data(push_req),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  tri_buf #(
    .WIDTH(BUS_WIDTH)
  ) u_tri_buf (
    .rw  (drive_en_reg),
    .data(drive_val_reg),
    .bus (bus)
  );

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = ADDR;
        end
      end
      ADDR: state_next = cur_reg.write ? WDATA : RDATA;
`ifdef RAM_MASTER_TURNAROUND_EN
      RDATA: state_next = TURN;
      WDATA, TURN: begin
`else
      WDATA, RDATA, TURN: begin
`endif
        pop        = !empty;
        state_next = empty ? IDLE : ADDR;
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus controls are registered from the next state so they change cleanly on the edge.
  always_ff @(posedge clock) begin
    if (!n_reset) begin
      state_reg     <= IDLE;
      cur_reg       <= '0;
      enable_reg    <= 1'b0;
      rw_reg        <= 1'b0;
      drive_en_reg  <= 1'b0;
      drive_val_reg <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      if (pop) cur_reg <= head;
      enable_reg    <= (state_next == ADDR) || (state_next == WDATA) || (state_next == RDATA);
      rw_reg        <= (state_next == WDATA) || ((state_next == ADDR) && next_req.write);
      drive_en_reg  <= (state_next == ADDR) || (state_next == WDATA);
      drive_val_reg <= (state_next == ADDR) ? next_req.addr : next_req.wdata;
      rsp_valid_reg <= (state_reg == RDATA);
      if (state_reg == RDATA) rsp_rdata_reg <= bus;
    end
  end

endmodule

// File: tb/tb_ram_bus_master.sv
// Scoreboard bench for ram_bus_master with a behavioural two-phase RAM on the shared bus.
module tb_ram_bus_master;

  logic       clock = 1'b0;
  logic       n_reset;
  logic       req_valid;
  logic       req_write;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       req_ready;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic       enable;
  logic       rw;
  wire  [7:0] bus;

  always #5 clock = ~clock;

  ram_bus_master #(
    .BUS_WIDTH (8),
    .FIFO_DEPTH(4)
  ) dut (
    .clock    (clock),
    .n_reset  (n_reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .busy     (busy),
    .enable   (enable),
    .rw       (rw),
    .bus      (bus)
  );

  // Behavioural RAM: first enabled cycle latches the address, second moves data.
  logic [7:0] ram_mem [256];
  logic       ram_phase;
  logic [7:0] ram_addr;

  initial begin
    for (int i = 0; i < 256; i++) ram_mem[i] = 8'h00;
  end

  always @(posedge clock) begin
    if (!n_reset || !enable) begin
      ram_phase <= 1'b0;
    end else if (!ram_phase) begin
      ram_phase <= 1'b1;
      ram_addr  <= bus;
    end else begin
      ram_phase <= 1'b0;
      if (rw) ram_mem[ram_addr] <= bus;
    end
  end

  assign bus = (enable && !rw && ram_phase) ? ram_mem[ram_addr] : 8'bzzzzzzzz;

  // Scoreboard state
  logic [16:0] exp_bus_q [$];
  logic [7:0]  exp_rsp_q [$];
  int          vectors = 0;
  int          miscompares = 0;
  int          stalls = 0;
  int          run_len = 0;
  int          max_run = 0;
  logic        after_read_pending = 1'b0;
  logic        last_after_read_en = 1'b0;
  logic        mon_write = 1'b0;
  logic [7:0]  mon_addr = 8'h00;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: decodes bus transactions and responses, compares against expectations.
  initial begin
    logic [16:0] e_bus;
    logic [7:0]  e_rsp;
    forever begin
      @(negedge clock);
      if (enable) run_len++;
      else run_len = 0;
      if (run_len > max_run) max_run = run_len;
      if (after_read_pending) begin
        last_after_read_en = enable;
        after_read_pending = 1'b0;
      end
      if (n_reset && enable) begin
        if (!ram_phase) begin
          mon_addr  = bus;
          mon_write = rw;
        end else begin
          check("rw_hold", {31'd0, rw}, {31'd0, mon_write});
          $display("bus txn: %s addr=0x%02h data=0x%02h", rw ? "write" : "read ", mon_addr, bus);
          if (exp_bus_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL bus_unexpected: got txn 0x%05h, expected none", {rw, mon_addr, bus});
          end else begin
            e_bus = exp_bus_q.pop_front();
            check("bus_txn", {15'd0, rw, mon_addr, bus}, {15'd0, e_bus});
          end
          if (!rw) after_read_pending = 1'b1;
        end
      end
      if (rsp_valid) begin
        $display("rsp: rdata=0x%02h", rsp_rdata);
        if (exp_rsp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL rsp_unexpected: got rdata 0x%02h, expected no pulse", rsp_rdata);
        end else begin
          e_rsp = exp_rsp_q.pop_front();
          check("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e_rsp});
        end
      end
    end
  end

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic push(input logic w, input logic [7:0] a, input logic [7:0] d, input logic [7:0] exp_rd);
    int waited = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    @(negedge clock);
    while (!req_ready && waited < 50) begin
      stalls++;
      waited++;
      @(negedge clock);
    end
    check("push_accept", {31'd0, req_ready}, 32'd1);
    if (w) begin
      exp_bus_q.push_back({1'b1, a, d});
    end else begin
      exp_bus_q.push_back({1'b0, a, exp_rd});
      exp_rsp_q.push_back(exp_rd);
    end
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    do begin
      @(negedge clock);
      #1;
      n++;
    end while ((busy || exp_bus_q.size() != 0 || exp_rsp_q.size() != 0) && n < 300);
    check("drain_busy", {31'd0, busy}, 32'd0);
    check("drain_queues", exp_bus_q.size() + exp_rsp_q.size(), 32'd0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    n_reset   = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 8'h55;
    req_wdata = 8'h66;

    // Reset held for 3 cycles while a request is offered
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_enable", {31'd0, enable}, 32'd0);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_req_ready", {31'd0, req_ready}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    n_reset   = 1'b1;
    @(negedge clock);
    check("post_reset_busy", {31'd0, busy}, 32'd0);
    @(posedge clock);
    #1;

    // Single write then read-back
    push(1'b1, 8'd10, 8'd15, 8'h00);
    drain();
    check("ram_mem10", {24'd0, ram_mem[10]}, 32'd15);
    push(1'b0, 8'd10, 8'h00, 8'd15);
    drain();

    // Back-to-back write burst: queue fills once, no idle cycle between writes
    stalls  = 0;
    max_run = 0;
    for (int i = 0; i < 8; i++) push(1'b1, 8'(i), 8'(8'hA0 + i), 8'h00);
    drain();
    check("burst_stalls", stalls, 32'd1);
    check("burst_enable_run", max_run, 32'd16);
    push(1'b0, 8'd0, 8'h00, 8'hA0);
    push(1'b0, 8'd4, 8'h00, 8'hA4);
    drain();

    // Write/read at the top address followed by another write: turnaround visibility
    push(1'b1, 8'd255, 8'h20, 8'h00);
    push(1'b0, 8'd255, 8'h00, 8'h20);
    push(1'b1, 8'd254, 8'h33, 8'h00);
    drain();
`ifdef RAM_MASTER_TURNAROUND_EN
    check("after_read_enable", {31'd0, last_after_read_en}, 32'd0);
`else
    check("after_read_enable", {31'd0, last_after_read_en}, 32'd1);
`endif

    // Reset asserted during the data phase of a read with a write still queued
    push(1'b0, 8'd10, 8'h00, 8'd15);
    push(1'b1, 8'd100, 8'h77, 8'h00);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      #1;
      if (enable && !rw && ram_phase) found = 1'b1;
    end
    check("rdata_phase_seen", {31'd0, found}, 32'd1);
    n_reset = 1'b0;
    exp_bus_q.delete();
    exp_rsp_q.delete();
    @(negedge clock);
    #1;
    check("abort_enable", {31'd0, enable}, 32'd0);
    check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clock);
    #1;
    n_reset = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    check("abort_lost_write", {24'd0, ram_mem[100]}, 32'd0);
    push(1'b0, 8'd10, 8'h00, 8'd15);
    push(1'b0, 8'd100, 8'h00, 8'h00);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
